// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned DEFAULT_DATA_BITS  = 8;
  // 8N1: start + payload + stop
  localparam int unsigned FRAME_BITS         = 1 + DEFAULT_DATA_BITS + 1;

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Line-side inputs and parallel-side outputs of the UART receiver.
interface uart_rx_oversampled_if #(
  parameter int unsigned DATA_BITS = uart_pkg::DEFAULT_DATA_BITS
);
  logic                 baud_tick;
  logic                 serial_in;
  logic [DATA_BITS-1:0] parallel_out;
  logic                 Load;
  logic                 frame_err;
  logic                 Busy;

  modport master (
    output baud_tick, serial_in,
    input  parallel_out, Load, frame_err, Busy
  );

  modport slave (
    input  baud_tick, serial_in,
    output parallel_out, Load, frame_err, Busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;
endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: mid-bit sampling on an oversampled tick, start-glitch rejection,
// framing-error detection and break handling.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_oversampled_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 load_q;
  logic                 err_q;
  logic                 busy_q;
  logic                 rx_s;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.serial_in),
    .dout (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Load is a single-clk strobe, independent of baud_tick.
      load_q <= 1'b0;
      if (bus.baud_tick) begin
        unique case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q <= START;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              if (!rx_s) begin
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DATA: begin
            if (cnt_q == BIT_LAST) begin
              shreg_q   <= {rx_s, shreg_q[DATA_BITS-1:1]};
              cnt_q     <= '0;
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              if (bit_idx_q == IDX_LAST) begin
                state_q <= STOP;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          STOP: begin
            if (cnt_q == BIT_LAST) begin
              cnt_q <= '0;
              if (rx_s) begin
                data_q  <= shreg_q;
                load_q  <= 1'b1;
                err_q   <= 1'b0;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                err_q   <= 1'b1;
                state_q <= BREAK;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          BREAK: begin
            // Stay here while the line is held low so a break never looks like a start bit.
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.parallel_out = data_q;
  assign bus.Load         = load_q;
  assign bus.frame_err    = err_q;
  assign bus.Busy         = busy_q;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Randomized self-checking bench: frames are built bit-by-bit on the line and the
// expected bytes / error flag come from a frame-level model.
module tb_uart_rx_oversampled;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_oversampled_if #(.DATA_BITS(8)) bus ();

  uart_rx_oversampled #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Tick generator: one tick every 4 clk while enabled.
  bit tick_en = 1'b1;
  int div = 0;
  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      bus.baud_tick = tick_en && (div == 0);
    end
  end

  // Monitor: Load pulses, double-width pulses, Busy ticks.
  logic [7:0] got_q[$];
  int dbl = 0;
  int busy_ticks = 0;
  bit prev_load = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bus.Load === 1'b1) begin
      got_q.push_back(bus.parallel_out);
      if (prev_load) dbl++;
    end
    prev_load = (bus.Load === 1'b1);
    if (bus.baud_tick && bus.Busy) busy_ticks++;
  end

  // Frame-level reference model.
  logic [7:0] exp_q[$];
  logic [7:0] exp_last = 8'h00;
  bit         exp_err  = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (bus.baud_tick !== 1'b1);
    end
  endtask

  task automatic set_line(input logic b);
    @(negedge clk);
    bus.serial_in = b;
  endtask

  task automatic freeze();
    int n0;
    n0 = got_q.size();
    tick_en = 1'b0;
    repeat (100) @(negedge clk);
    check("freeze_noload", got_q.size(), n0);
    check("freeze_busy", bus.Busy, 1);
    tick_en = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int freeze_bit);
    set_line(1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_line(d[i]);
      if (i == freeze_bit) begin
        wait_ticks(8);
        freeze();
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    set_line(stop);
    wait_ticks(16);
    if (stop) begin
      exp_q.push_back(d);
      exp_last = d;
      exp_err  = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic compare_loads(input string tag);
    check({tag, "_nloads"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_pout"}, bus.parallel_out, exp_last);
    check({tag, "_ferr"}, bus.frame_err, exp_err);
  endtask

  initial begin
    logic [7:0] d;
    bit stop;
    rst = 1'b1;
    bus.serial_in = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_pout", bus.parallel_out, 0);
    check("rst_load", bus.Load, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_busy", bus.Busy, 0);
    rst = 1'b0;
    wait_ticks(10);

    // Single frame.
    send_frame(8'hA5, 1'b1, -1);
    wait_ticks(10);
    compare_loads("t1");
    check_outputs("t1");
    check("t1_busy", bus.Busy, 0);

    // Start-bit glitch.
    busy_ticks = 0;
    set_line(1'b0);
    wait_ticks(4);
    set_line(1'b1);
    wait_ticks(20);
    check("t2_busy_seen", busy_ticks > 0, 1);
    check("t2_busy_max", busy_ticks <= 8, 1);
    check("t2_busy", bus.Busy, 0);
    compare_loads("t2");
    check_outputs("t2");

    // Framing error then break, then recovery.
    send_frame(8'h3C, 1'b0, -1);
    wait_ticks(40);
    compare_loads("t3a");
    check_outputs("t3a");
    check("t3a_busy", bus.Busy, 1);
    set_line(1'b1);
    wait_ticks(10);
    check("t3b_busy", bus.Busy, 0);
    check("t3b_ferr_sticky", bus.frame_err, 1);
    send_frame(8'h5F, 1'b1, -1);
    wait_ticks(10);
    compare_loads("t3c");
    check_outputs("t3c");

    // Back-to-back frames.
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_ticks(10);
    compare_loads("t4");
    check_outputs("t4");

    // Reset during data bit 3.
    d = 8'($urandom);
    set_line(1'b0);
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      set_line(d[i]);
      wait_ticks(16);
    end
    set_line(d[3]);
    wait_ticks(8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_last = 8'h00;
    exp_err  = 1'b0;
    check("t5_rst_busy", bus.Busy, 0);
    check("t5_rst_load", bus.Load, 0);
    check_outputs("t5_rst");
    set_line(1'b1);
    wait_ticks(30);
    compare_loads("t5a");
    send_frame(8'h81, 1'b1, -1);
    wait_ticks(10);
    compare_loads("t5b");
    check_outputs("t5b");

    // Tick freeze mid-frame.
    send_frame(8'h5A, 1'b1, 4);
    wait_ticks(10);
    compare_loads("t6");
    check_outputs("t6");

    // Random frames with random gaps and occasional framing errors.
    for (int f = 0; f < 12; f++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, stop, -1);
      if (!stop) begin
        wait_ticks($urandom_range(0, 20));
        set_line(1'b1);
        wait_ticks(4);
      end
      wait_ticks($urandom_range(0, 3));
    end
    wait_ticks(10);
    compare_loads("rnd");
    check_outputs("rnd");
    check("load_width", dbl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
